// File: rtl/mul_lat4_stream.sv
// rtl/mul_lat4_stream.sv - ready/valid streaming shell around a fixed-latency, non-stallable multiplier
//
// Purpose:
//   Accepts operand pairs on a ready/valid input, presents them to an external
//   LATENCY-stage multiplier, tracks in-flight products with a valid shift
//   register and captures each product into an output FIFO. A credit counter
//   limits outstanding operations to DEPTH so no product is ever dropped while
//   the consumer applies backpressure.
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      shell can accept an operand pair
//   in_a       in   WIDTH  operand a
//   in_b       in   WIDTH  operand b
//   mul_a      out  WIDTH  to multiplier input a (zero when not firing)
//   mul_b      out  WIDTH  to multiplier input b (zero when not firing)
//   mul_out    in   WIDTH  from multiplier output, LATENCY cycles after mul_a/mul_b
//   out_valid  out  1      product available
//   out_ready  in   1      consumer takes product
//   out_data   out  WIDTH  product, in acceptance order
//   busy       out  1      any op in flight or buffered

module mul_lat4_stream #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,   // must be >= 2
    parameter int DEPTH   = 8    // power of 2, >= LATENCY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [LATENCY-1:0] vld_sr;
    logic [AW:0]        used;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic fire;
    logic pop;
    logic wr_en;
    logic full;
    logic empty;

    // Credits count every op from acceptance until it is popped, so the FIFO
    // always has a slot reserved for each product still in the multiplier.
    assign in_ready = (used < DEPTH_C);
    assign fire     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign busy     = (used != '0);

    // Idle cycles drive zeros so the multiplier inputs do not toggle on
    // whatever the upstream leaves on in_a/in_b.
    assign mul_a = fire ? in_a : '0;
    assign mul_b = fire ? in_b : '0;

    assign wr_en = vld_sr[LATENCY-1];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
            used   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], fire};
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            case ({fire, pop})
                2'b10:   used <= used + ONE_C;
                2'b01:   used <= used - ONE_C;
                default: used <= used;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= mul_out;
        end
    end

endmodule
